// File: rtl/mdb_bus_arbiter.sv
// mdb_bus_arbiter: round-robin arbiter/sequencer for the shared multi-drop bus
//    feeding the A/B/C destination register bank. Grants one of three requesters,
//    drives Bus/EN for HOLD_CYCLES cycles, then releases and pulses Done.
// Latency: grant, Bus and EN register at the first edge a request is seen in IDLE.
//    Done pulses HOLD_CYCLES edges later. Busy drops one edge after that.
// Backpressure: none. Req is a level held until Done. Arbitration only happens in
//    IDLE, so the bus carries one transfer per HOLD_CYCLES+2 cycles at most.
// Ports:
//    i_clk, i_reset_n (synchronous, active-low)
//    i_req[2:0], i_data0..2, i_dest0..2 (00 none, 01 A, 10 B, 11 C)
//    o_gnt (one-hot), o_done (one-cycle pulse), o_bus, o_en, o_busy
// Option: define MDB_FIXED_PRIORITY_EN for fixed priority 0 > 1 > 2 (pointer frozen at 0).
module mdb_bus_arbiter #(
   parameter int DATA_W      = 8,
   parameter int HOLD_CYCLES = 1   // legal range 1..15
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic [2:0]        i_req,
   input  logic [DATA_W-1:0] i_data0,
   input  logic [DATA_W-1:0] i_data1,
   input  logic [DATA_W-1:0] i_data2,
   input  logic [1:0]        i_dest0,
   input  logic [1:0]        i_dest1,
   input  logic [1:0]        i_dest2,
   output logic [2:0]        o_gnt,
   output logic [2:0]        o_done,
   output logic [DATA_W-1:0] o_bus,
   output logic [1:0]        o_en,
   output logic              o_busy
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_DRIVE   = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;

   localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

   logic [1:0]        r_state;
   logic [3:0]        r_cnt;
   logic [1:0]        r_ptr;
   logic [2:0]        r_gnt;
   logic [2:0]        r_done;
   logic [DATA_W-1:0] r_bus;
   logic [1:0]        r_en;
   logic              r_busy;

   logic [1:0]        w_win;
   logic [1:0]        w_ptr_nxt;
   logic [2:0]        w_gnt_oh;
   logic [DATA_W-1:0] w_data;
   logic [1:0]        w_dest;

   // First set request searching from start, wrapping modulo 3.
   function automatic logic [1:0] pick(input logic [2:0] req, input logic [1:0] start);
      logic [1:0] w;
      w = 2'd0;
      case (start)
         2'd1:    if (req[1]) w = 2'd1; else if (req[2]) w = 2'd2; else w = 2'd0;
         2'd2:    if (req[2]) w = 2'd2; else if (req[0]) w = 2'd0; else w = 2'd1;
         default: if (req[0]) w = 2'd0; else if (req[1]) w = 2'd1; else w = 2'd2;
      endcase
      return w;
   endfunction

   // In fixed-priority builds r_ptr never leaves 0, so the same search
   // degenerates to 0 > 1 > 2.
   assign w_win    = pick(i_req, r_ptr);
   assign w_gnt_oh = 3'b001 << w_win;

   always_comb begin
      w_data    = i_data0;
      w_dest    = i_dest0;
      w_ptr_nxt = 2'd1;
      case (w_win)
         2'd1: begin
            w_data    = i_data1;
            w_dest    = i_dest1;
            w_ptr_nxt = 2'd2;
         end
         2'd2: begin
            w_data    = i_data2;
            w_dest    = i_dest2;
            w_ptr_nxt = 2'd0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_ptr   <= 2'd0;
         r_gnt   <= 3'b000;
         r_done  <= 3'b000;
         r_bus   <= '0;
         r_en    <= 2'b00;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|i_req) begin
                  r_gnt   <= w_gnt_oh;
                  r_bus   <= w_data;
                  r_en    <= w_dest;
                  r_busy  <= 1'b1;
                  r_cnt   <= HOLD_LOAD;
                  r_state <= ST_DRIVE;
`ifdef MDB_FIXED_PRIORITY_EN
                  r_ptr   <= 2'd0;
`else
                  r_ptr   <= w_ptr_nxt;
`endif
               end
            end
            ST_DRIVE: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  // Done goes to whoever held the grant; Busy stays up through RELEASE.
                  r_done  <= r_gnt;
                  r_gnt   <= 3'b000;
                  r_en    <= 2'b00;
                  r_bus   <= '0;
                  r_state <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               r_done  <= 3'b000;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_gnt  = r_gnt;
   assign o_done = r_done;
   assign o_bus  = r_bus;
   assign o_en   = r_en;
   assign o_busy = r_busy;

endmodule

// File: tb/tb_mdb_bus_arbiter.sv
// tb_mdb_bus_arbiter: directed bench for mdb_bus_arbiter with two instances,
//    HOLD_CYCLES=1 (u_dut1) and HOLD_CYCLES=4 (u_dut4), sharing all inputs.
//    Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_mdb_bus_arbiter;

   logic       clk;
   logic       rst_n;
   logic [2:0] req;
   logic [7:0] d0, d1, d2;
   logic [1:0] dest0, dest1, dest2;

   logic [2:0] gnt1, done1, gnt4, done4;
   logic [7:0] bus1, bus4;
   logic [1:0] en1, en4;
   logic       busy1, busy4;

   int n_chk = 0;
   int n_err = 0;

   mdb_bus_arbiter #(.DATA_W(8), .HOLD_CYCLES(1)) u_dut1 (
      .i_clk(clk), .i_reset_n(rst_n), .i_req(req),
      .i_data0(d0), .i_data1(d1), .i_data2(d2),
      .i_dest0(dest0), .i_dest1(dest1), .i_dest2(dest2),
      .o_gnt(gnt1), .o_done(done1), .o_bus(bus1), .o_en(en1), .o_busy(busy1)
   );

   mdb_bus_arbiter #(.DATA_W(8), .HOLD_CYCLES(4)) u_dut4 (
      .i_clk(clk), .i_reset_n(rst_n), .i_req(req),
      .i_data0(d0), .i_data1(d1), .i_data2(d2),
      .i_dest0(dest0), .i_dest1(dest1), .i_dest2(dest2),
      .o_gnt(gnt4), .o_done(done4), .o_bus(bus4), .o_en(en4), .o_busy(busy4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req   = 3'b000;
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 3'b111;
      d0 = 8'h11; d1 = 8'h22; d2 = 8'h33;
      dest0 = 2'b01; dest1 = 2'b01; dest2 = 2'b01;

      // Reset held with all requests pending
      step();
      step();
      chk("rst_gnt",  32'(gnt1),  'h0);
      chk("rst_en",   32'(en1),   'h0);
      chk("rst_bus",  32'(bus1),  'h0);
      chk("rst_busy", 32'(busy1), 'h0);
      chk("rst_done", 32'(done1), 'h0);
      chk("rst_gnt4", 32'(gnt4),  'h0);
      rst_n = 1'b1;
      step();
      chk("rel_gnt",  32'(gnt1), 'h1);
      chk("rel_gnt4", 32'(gnt4), 'h1);

      // Single transfer, HOLD_CYCLES=1
      do_reset();
      req = 3'b010; d1 = 8'hA5; dest1 = 2'b10;
      step();
      chk("single_gnt",  32'(gnt1),  'h2);
      chk("single_bus",  32'(bus1),  'hA5);
      chk("single_en",   32'(en1),   'h2);
      chk("single_busy", 32'(busy1), 'h1);
      step();
      chk("single_en_rel",   32'(en1),   'h0);
      chk("single_done",     32'(done1), 'h2);
      chk("single_gnt_rel",  32'(gnt1),  'h0);
      chk("single_busy_rel", 32'(busy1), 'h1);
      req = 3'b000;
      step();
      chk("single_busy_end", 32'(busy1), 'h0);
      chk("single_done_end", 32'(done1), 'h0);

      // Round-robin with all three requesting continuously
      do_reset();
      req = 3'b111; d0 = 8'h11; d1 = 8'h22; d2 = 8'h33;
      dest0 = 2'b01; dest1 = 2'b01; dest2 = 2'b01;
      for (int t = 0; t < 4; t++) begin
         logic [2:0] exp_gnt;
         logic [7:0] exp_bus;
         case (t % 3)
            0:       begin exp_gnt = 3'b001; exp_bus = 8'h11; end
            1:       begin exp_gnt = 3'b010; exp_bus = 8'h22; end
            default: begin exp_gnt = 3'b100; exp_bus = 8'h33; end
         endcase
         step();
         chk("rr_gnt", 32'(gnt1), 32'(exp_gnt));
         chk("rr_bus", 32'(bus1), 32'(exp_bus));
         chk("rr_en",  32'(en1),  'h1);
         step();
         chk("rr_done", 32'(done1), 32'(exp_gnt));
         step();
         chk("rr_idle", 32'(busy1), 'h0);
      end

      // Hold length, HOLD_CYCLES=4
      do_reset();
      req = 3'b100; d2 = 8'h3C; dest2 = 2'b11;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("hold_bus",  32'(bus4),  'h3C);
         chk("hold_en",   32'(en4),   'h3);
         chk("hold_gnt",  32'(gnt4),  'h4);
         chk("hold_done", 32'(done4), 'h0);
      end
      step();
      chk("hold_en_rel", 32'(en4),   'h0);
      chk("hold_done1",  32'(done4), 'h4);
      req = 3'b000;
      step();
      chk("hold_done_end", 32'(done4), 'h0);
      chk("hold_busy_end", 32'(busy4), 'h0);

      // Null destination and data change during DRIVE
      do_reset();
      req = 3'b001; d0 = 8'h5A; dest0 = 2'b00;
      step();
      chk("null_gnt",  32'(gnt1), 'h1);
      chk("null_en",   32'(en1),  'h0);
      chk("null_bus",  32'(bus1), 'h5A);
      chk("null_gnt4", 32'(gnt4), 'h1);
      d0 = 8'hFF;
      step();
      chk("null_done",  32'(done1), 'h1);
      chk("null_en_r",  32'(en1),   'h0);
      chk("capt_bus_a", 32'(bus4),  'h5A);
      step();
      chk("capt_bus_b", 32'(bus4), 'h5A);
      chk("null_en4",   32'(en4),  'h0);
      step();
      chk("capt_bus_c", 32'(bus4), 'h5A);
      step();
      chk("null_done4", 32'(done4), 'h1);
      req = 3'b000;
      step();
      chk("null_busy4", 32'(busy4), 'h0);

      // Reset during the 2nd DRIVE cycle of a HOLD_CYCLES=4 transfer
      do_reset();
      req = 3'b010; d1 = 8'h77; dest1 = 2'b01;
      step();
      chk("mid_gnt", 32'(gnt4), 'h2);
      step();
      rst_n = 1'b0;
      step();
      chk("mid_gnt_r",  32'(gnt4),  'h0);
      chk("mid_en_r",   32'(en4),   'h0);
      chk("mid_bus_r",  32'(bus4),  'h0);
      chk("mid_busy_r", 32'(busy4), 'h0);
      chk("mid_done_r", 32'(done4), 'h0);
      rst_n = 1'b1;
      req = 3'b111;
      step();
      chk("mid_ptr0", 32'(gnt4), 'h1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("mid_no_done", 32'(done4 & 3'b110), 'h0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
